image_stream_source: RTL and testbench

Raster-scan pixel transmitter: on `start`, it reads an IMG_WIDTH × IMG_HEIGHT 8-bit grayscale frame from a synchronous single-port frame RAM and drives it out as the `pixel_out`/`data_valid` stream that the Sobel edge pipeline consumes on its `pixel_in`/`data_valid` inputs. It sits between the frame-buffer RAM and the edge detector's window generator. It can insert programmable blanking between lines and accepts a `hold` throttle.

---
 rtl/image_stream_source_if.sv | 30 +++
 rtl/image_stream_source.sv | 173 +++++++++++++++++
 tb/tb_image_stream_source.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_stream_source_if.sv
// Bus bundle for image_stream_source.
// Carries two groups of signals:
//   - frame RAM read port: mem_rd_en, mem_addr (to RAM), mem_rd_data (from RAM,
//     valid the cycle after mem_rd_en)
//   - pixel stream to the edge pipeline: pixel_out, data_valid, frame_start,
//     line_end, frame_done
// The master modport is the pixel source. The slave modport is the RAM plus
// the stream consumer.
interface image_stream_source_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic [7:0]        pixel_out;
  logic              data_valid;
  logic              frame_start;
  logic              line_end;
  logic              frame_done;

  modport master (
    output mem_rd_en, mem_addr, pixel_out, data_valid, frame_start, line_end, frame_done,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en, mem_addr, pixel_out, data_valid, frame_start, line_end, frame_done,
    output mem_rd_data
  );
endinterface

// File: rtl/image_stream_source.sv
// Raster-scan pixel transmitter.
// On start, reads an IMG_WIDTH x IMG_HEIGHT 8-bit frame from a synchronous
// frame RAM and streams it to the edge pipeline. LINE_GAP idle cycles can be
// inserted between lines, and hold throttles the RAM reads.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset
//   start - begin a frame (sampled in idle)
//   hold  - while high, no new RAM read is issued
//   busy  - high from leaving idle through the last data_valid
//   bus   - image_stream_source_if.master (RAM read port + pixel stream)
//
// Optional build macro: SRC_CONTINUOUS_EN. When it is defined, start held
// high during drain restarts the next frame without passing through idle.
//
// Latency: mem_rd_en in cycle k gives data_valid in cycle k+2.
module image_stream_source #(
  parameter int unsigned IMG_WIDTH  = 256,
  parameter int unsigned IMG_HEIGHT = 256,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_GAP   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  output logic                 busy,
  image_stream_source_if.master bus
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  // The gap counter is also reused as the 2-cycle drain counter, so it needs at least 1 bit.
  localparam int unsigned GapW = (LINE_GAP > 2) ? $clog2(LINE_GAP) : 1;

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

  typedef enum logic [1:0] {StIdle, StStream, StGap, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [GapW-1:0]   cnt_q, cnt_d;
  logic              rd_en, eol, last_px;

  // Tags travel alongside the RAM read so they line up with mem_rd_data.
  logic       s1_valid_q, s1_first_q, s1_eol_q, s1_last_q;
  logic [7:0] pixel_q;
  logic       valid_q, fs_q, le_q, fd_q;

  assign eol     = (col_q == ColLast);
  assign last_px = eol && (row_q == RowLast);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStream;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      StStream: begin
        if (!hold) begin
          rd_en = 1'b1;
          if (last_px) begin
            // Wrap addr so it never shows a value past the frame.
            col_d   = '0;
            row_d   = '0;
            addr_d  = '0;
            cnt_d   = '0;
            state_d = StDrain;
          end else if (eol) begin
            col_d  = '0;
            row_d  = row_q + 1'b1;
            addr_d = addr_q + 1'b1;
            cnt_d  = '0;
            if (LINE_GAP != 0) state_d = StGap;
          end else begin
            col_d  = col_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StStream;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        // Two cycles for the last read to pass through RAM and output stages.
        if (cnt_q == GapW'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef SRC_CONTINUOUS_EN
        if (start) begin
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          cnt_d   = '0;
          state_d = (LINE_GAP != 0) ? StGap : StStream;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_eol_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      pixel_q    <= '0;
      valid_q    <= 1'b0;
      fs_q       <= 1'b0;
      le_q       <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      s1_valid_q <= rd_en;
      s1_first_q <= rd_en && (col_q == '0) && (row_q == '0);
      s1_eol_q   <= rd_en && eol;
      s1_last_q  <= rd_en && last_px;
      valid_q    <= s1_valid_q;
      fs_q       <= s1_first_q;
      le_q       <= s1_eol_q;
      fd_q       <= s1_last_q;
      if (s1_valid_q) pixel_q <= bus.mem_rd_data;
    end
  end

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_addr    = addr_q;
  assign bus.pixel_out   = pixel_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_start = fs_q;
  assign bus.line_end    = le_q;
  assign bus.frame_done  = fd_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_image_stream_source.sv
module tb_image_stream_source;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0, hold0 = 1'b0, busy0;
  logic start2 = 1'b0, hold2 = 1'b0, busy2;

  int total = 0;
  int bad   = 0;

  image_stream_source_if #(.ADDR_W(AW)) bus0 ();
  image_stream_source_if #(.ADDR_W(AW)) bus2 ();

  image_stream_source #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (AW),
    .LINE_GAP  (0)
  ) dut0 (
    .clk  (clk),
    .rst  (rst),
    .start(start0),
    .hold (hold0),
    .busy (busy0),
    .bus  (bus0)
  );

  image_stream_source #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (AW),
    .LINE_GAP  (2)
  ) dut2 (
    .clk  (clk),
    .rst  (rst),
    .start(start2),
    .hold (hold2),
    .busy (busy2),
    .bus  (bus2)
  );

  always #5 clk = ~clk;

  // Frame RAM models: RAM[a] = 8'h10 + a, one-cycle read latency.
  always @(posedge clk) begin
    if (bus0.mem_rd_en) bus0.mem_rd_data <= 8'h10 + {4'h0, bus0.mem_addr};
    if (bus2.mem_rd_en) bus2.mem_rd_data <= 8'h10 + {4'h0, bus2.mem_addr};
  end

  // Capture buffers, indexed by pixel number or by cycle offset from start.
  logic [7:0] pix     [64];
  int         dv_t    [64];
  logic [2:0] flags   [64]; // {frame_start, line_end, frame_done}
  logic       rd_tr   [64];
  logic       busy_tr [64];
  int         n;

  // Cycle t=0 is the cycle in which start is first driven high.
  task automatic run_capture(input bit sel, input int hold_from, input int hold_cnt,
                             input int start_cycles, input int ncyc);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      pix[i] = 8'h00; dv_t[i] = -1; flags[i] = 3'b000; rd_tr[i] = 1'b0; busy_tr[i] = 1'b0;
    end
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk); #1;
      if (sel) begin
        start2 = (t < start_cycles);
        hold2  = (t >= hold_from) && (t < hold_from + hold_cnt);
      end else begin
        start0 = (t < start_cycles);
        hold0  = (t >= hold_from) && (t < hold_from + hold_cnt);
      end
      @(negedge clk);
      rd_tr[t]   = sel ? bus2.mem_rd_en : bus0.mem_rd_en;
      busy_tr[t] = sel ? busy2 : busy0;
      if ((sel ? bus2.data_valid : bus0.data_valid) && n < 64) begin
        pix[n]   = sel ? bus2.pixel_out : bus0.pixel_out;
        dv_t[n]  = t;
        flags[n] = sel ? {bus2.frame_start, bus2.line_end, bus2.frame_done}
                       : {bus0.frame_start, bus0.line_end, bus0.frame_done};
        n++;
      end
    end
    start0 = 1'b0; hold0 = 1'b0; start2 = 1'b0; hold2 = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    int k;
    k = 0;
    @(negedge clk);
    while ((sel ? busy2 : busy0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if ((sel ? busy2 : busy0) !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout: busy got %b want 0", sel ? busy2 : busy0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [24:0] v0, v2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v0 = {bus0.mem_rd_en, bus0.mem_addr, bus0.pixel_out, bus0.data_valid, bus0.frame_start,
          bus0.line_end, bus0.frame_done, busy0, 5'b0};
    v2 = {bus2.mem_rd_en, bus2.mem_addr, bus2.pixel_out, bus2.data_valid, bus2.frame_start,
          bus2.line_end, bus2.frame_done, busy2, 5'b0};
    total++;
    if (v0 !== 25'h0) begin bad++; $display("FAIL reset_outputs_gap0: got %h want 0", v0); end
    total++;
    if (v2 !== 25'h0) begin bad++; $display("FAIL reset_outputs_gap2: got %h want 0", v2); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_stream;
    logic [7:0] exp_px;
    logic [2:0] exp_fl;
    int first_rd;
    run_capture(1'b0, 99, 0, 1, 20);
    total++;
    if (n !== 12) begin bad++; $display("FAIL stream_count: got %0d want 12", n); end
    for (int i = 0; i < 12; i++) begin
      exp_px = 8'h10 + 8'(i);
      exp_fl = {(i == 0), (i % 4 == 3), (i == 11)};
      total++;
      if (pix[i] !== exp_px) begin
        bad++; $display("FAIL stream_pixel[%0d]: got %h want %h", i, pix[i], exp_px);
      end
      total++;
      if (dv_t[i] !== 3 + i) begin
        bad++; $display("FAIL stream_dv_cycle[%0d]: got %0d want %0d", i, dv_t[i], 3 + i);
      end
      total++;
      if (flags[i] !== exp_fl) begin
        bad++; $display("FAIL stream_flags[%0d]: got %b want %b", i, flags[i], exp_fl);
      end
    end
    first_rd = -1;
    for (int t = 19; t >= 0; t--) if (rd_tr[t]) first_rd = t;
    total++;
    if (first_rd !== 1) begin bad++; $display("FAIL first_rd_cycle: got %0d want 1", first_rd); end
    total++;
    if (dv_t[0] - first_rd !== 2) begin
      bad++; $display("FAIL rd_to_dv_latency: got %0d want 2", dv_t[0] - first_rd);
    end
    total++;
    if ({busy_tr[0], busy_tr[1], busy_tr[14], busy_tr[15]} !== 4'b0110) begin
      bad++;
      $display("FAIL stream_busy: got %b want 0110",
               {busy_tr[0], busy_tr[1], busy_tr[14], busy_tr[15]});
    end
    wait_idle(1'b0);
  endtask

  task automatic test_line_gap;
    logic [7:0] exp_px;
    run_capture(1'b1, 99, 0, 1, 24);
    total++;
    if (n !== 12) begin bad++; $display("FAIL gap_count: got %0d want 12", n); end
    for (int i = 0; i < 12; i++) begin
      exp_px = 8'h10 + 8'(i);
      total++;
      if (pix[i] !== exp_px) begin
        bad++; $display("FAIL gap_pixel[%0d]: got %h want %h", i, pix[i], exp_px);
      end
    end
    total++;
    if (dv_t[4] - dv_t[3] !== 3) begin
      bad++; $display("FAIL gap_after_13: got %0d want 3", dv_t[4] - dv_t[3]);
    end
    total++;
    if (dv_t[8] - dv_t[7] !== 3) begin
      bad++; $display("FAIL gap_after_17: got %0d want 3", dv_t[8] - dv_t[7]);
    end
    total++;
    if (dv_t[11] - dv_t[0] + 1 !== 16) begin
      bad++; $display("FAIL gap_span: got %0d want 16", dv_t[11] - dv_t[0] + 1);
    end
    wait_idle(1'b1);
  endtask

  task automatic test_hold;
    logic [7:0] exp_px;
    // Row 1, col 2 (addr 6) is reached at cycle 7 when unthrottled.
    run_capture(1'b0, 7, 3, 1, 24);
    total++;
    if (n !== 12) begin bad++; $display("FAIL hold_count: got %0d want 12", n); end
    for (int i = 0; i < 12; i++) begin
      exp_px = 8'h10 + 8'(i);
      total++;
      if (pix[i] !== exp_px) begin
        bad++; $display("FAIL hold_pixel[%0d]: got %h want %h", i, pix[i], exp_px);
      end
    end
    total++;
    if ({rd_tr[6], rd_tr[7], rd_tr[8], rd_tr[9], rd_tr[10]} !== 5'b10001) begin
      bad++;
      $display("FAIL hold_rd_en: got %b want 10001",
               {rd_tr[6], rd_tr[7], rd_tr[8], rd_tr[9], rd_tr[10]});
    end
    total++;
    if (dv_t[6] - dv_t[5] !== 4) begin
      bad++; $display("FAIL hold_gap_15_16: got %0d want 4", dv_t[6] - dv_t[5]);
    end
    wait_idle(1'b0);
  endtask

  task automatic test_reset_mid;
    logic [24:0] v0;
    for (int t = 0; t < 7; t++) begin
      @(posedge clk); #1;
      start0 = (t == 0);
      rst    = (t != 6);
      @(negedge clk);
      if (t == 6) begin
        total++;
        if ({bus0.data_valid, bus0.pixel_out} !== {1'b1, 8'h13}) begin
          bad++;
          $display("FAIL mid_pre_reset: got %b/%h want 1/13", bus0.data_valid, bus0.pixel_out);
        end
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    v0 = {bus0.mem_rd_en, bus0.mem_addr, bus0.pixel_out, bus0.data_valid, bus0.frame_start,
          bus0.line_end, bus0.frame_done, busy0, 5'b0};
    total++;
    if (v0 !== 25'h0) begin bad++; $display("FAIL mid_reset_outputs: got %h want 0", v0); end
    run_capture(1'b0, 99, 0, 1, 20);
    total++;
    if (n !== 12) begin bad++; $display("FAIL mid_restart_count: got %0d want 12", n); end
    total++;
    if ({pix[0], flags[0]} !== {8'h10, 3'b100}) begin
      bad++; $display("FAIL mid_restart_first: got %h/%b want 10/100", pix[0], flags[0]);
    end
    total++;
    if (dv_t[0] !== 3) begin bad++; $display("FAIL mid_restart_dv: got %0d want 3", dv_t[0]); end
    wait_idle(1'b0);
  endtask

  task automatic test_start_held;
    logic all_busy;
    run_capture(1'b0, 99, 0, 40, 40);
    total++;
    if ({pix[11], flags[11]} !== {8'h1B, 3'b011}) begin
      bad++; $display("FAIL held_frame1_last: got %h/%b want 1b/011", pix[11], flags[11]);
    end
    total++;
    if ({pix[12], flags[12]} !== {8'h10, 3'b100}) begin
      bad++; $display("FAIL held_frame2_first: got %h/%b want 10/100", pix[12], flags[12]);
    end
`ifdef SRC_CONTINUOUS_EN
    total++;
    if (dv_t[12] - dv_t[11] !== 2) begin
      bad++; $display("FAIL cont_restart_gap: got %0d want 2", dv_t[12] - dv_t[11]);
    end
    all_busy = 1'b1;
    for (int t = 1; t < 40; t++) all_busy = all_busy & busy_tr[t];
    total++;
    if (all_busy !== 1'b1) begin bad++; $display("FAIL cont_busy: got %b want 1", all_busy); end
`else
    total++;
    if (busy_tr[15] !== 1'b0) begin
      bad++; $display("FAIL held_idle_pass: busy got %b want 0", busy_tr[15]);
    end
    total++;
    if (dv_t[12] !== 18) begin bad++; $display("FAIL held_restart_dv: got %0d want 18", dv_t[12]); end
    all_busy = busy_tr[16] & busy_tr[29];
    total++;
    if (all_busy !== 1'b1) begin bad++; $display("FAIL held_frame2_busy: got %b want 1", all_busy); end
`endif
    wait_idle(1'b0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_line_gap();
    test_hold();
    test_reset_mid();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
